// File: rtl/sha_pkg.sv
// sha_pkg: shared hash types, tag record and width helpers for the SHA core arbiter
package sha_pkg;
   localparam int ID_W = 3;
   typedef logic [7:0][31:0] hash_state_t;
   typedef struct packed {
      logic valid;
      logic [ID_W-1:0] id;
   } tag_t;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_w(input int m);
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/sha_tag_delay_line.sv
// sha_tag_delay_line: fixed-depth shift register of {valid, data}; reset clears only the valids
module sha_tag_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) v <= '0;
      else begin
         v[0] <= valid_i;
         for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
      end
   end
   always_ff @(posedge clk) begin
      d[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
   end
   assign valid_o = v[DEPTH-1];
   assign data_o = d[DEPTH-1];
endmodule

// File: rtl/sha_core_rr_arbiter.sv
// sha_core_rr_arbiter: round-robin sharing of one pipelined SHA-256 core with message lock,
// per-requester credits and id-tagged result routing
module sha_core_rr_arbiter
   import sha_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CORE_LATENCY = 64,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][15:0][31:0]  req_W,
   input  logic [NUM_REQ-1:0][7:0][31:0]   req_state,
   input  logic [NUM_REQ-1:0]              req_newblock,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic                            core_valid_o,
   output logic [15:0][31:0]               core_W_o,
   output hash_state_t                     core_state_o,
   output logic                            core_newblock_o,
   input  logic                            core_valid_i,
   input  hash_state_t                     core_state_i,
   output logic [NUM_REQ-1:0]              resp_valid,
   output hash_state_t                     resp_state,
   output logic                            err_tag_mismatch
);
   localparam int IW = id_w(NUM_REQ);
   localparam int CW = cnt_w(MAX_OUTSTANDING);
   logic [IW-1:0] ptr, lock_id, gnt_id, tail_id;
   logic [IW:0] s;
   logic lock, gnt, tail_v, hit;
   logic [NUM_REQ-1:0][CW-1:0] credits;
   logic [NUM_REQ-1:0] elig;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign elig[i] = req_valid[i] && (credits[i] < CW'(MAX_OUTSTANDING));
   end
   // descending scan so the candidate nearest ptr is the one that sticks
   always_comb begin
      gnt = 1'b0;
      gnt_id = lock_id;
      s = '0;
      if (lock) gnt = elig[lock_id];
      else
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
            if (elig[s[IW-1:0]]) begin
               gnt = 1'b1;
               gnt_id = s[IW-1:0];
            end
         end
      gnt = gnt && rst;
   end
   assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
   assign hit = core_valid_i && tail_v;
   sha_tag_delay_line #(.WIDTH(IW), .DEPTH(CORE_LATENCY + 1)) u_tags (
      .clk(clk), .rst(rst), .valid_i(gnt), .data_i(gnt_id), .valid_o(tail_v), .data_o(tail_id)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         lock <= 1'b0;
         lock_id <= '0;
         core_valid_o <= 1'b0;
         core_W_o <= '0;
         core_state_o <= '0;
         core_newblock_o <= 1'b0;
         resp_valid <= '0;
         resp_state <= '0;
         err_tag_mismatch <= 1'b0;
         credits <= '0;
      end else begin
         core_valid_o <= gnt;
         if (gnt) begin
            core_W_o <= req_W[gnt_id];
            core_state_o <= req_state[gnt_id];
            core_newblock_o <= req_newblock[gnt_id];
            lock <= !req_last[gnt_id];
            lock_id <= gnt_id;
            if (!lock) ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         end
         resp_valid <= hit ? (NUM_REQ'(1) << tail_id) : '0;
         if (hit) resp_state <= core_state_i;
         err_tag_mismatch <= err_tag_mismatch || (core_valid_i != tail_v);
         for (int i = 0; i < NUM_REQ; i++)
            credits[i] <= credits[i] + CW'(req_ready[i]) - CW'(resp_valid[i]);
      end
   end
endmodule

// File: tb/tb_sha_core_rr_arbiter.sv
// tb_sha_core_rr_arbiter: vector table plus random traffic against a scoreboard model
module tb_sha_core_rr_arbiter;
   localparam int N = 2;
   localparam int L = 8;
   localparam int MAXO = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready, req_newblock = '0, req_last = '0, resp_valid;
   logic [N-1:0][15:0][31:0] req_W = '0;
   logic [N-1:0][7:0][31:0] req_state = '0;
   logic core_valid_o, core_newblock_o, core_valid_i, err_tag_mismatch;
   logic [15:0][31:0] core_W_o;
   logic [7:0][31:0] core_state_o, core_state_i, resp_state;
   logic inj = 1'b0;
   logic pv [L];
   logic [255:0] ps [L];
   sha_core_rr_arbiter #(.NUM_REQ(N), .CORE_LATENCY(L), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_W(req_W),
      .req_state(req_state), .req_newblock(req_newblock), .req_last(req_last),
      .core_valid_o(core_valid_o), .core_W_o(core_W_o), .core_state_o(core_state_o),
      .core_newblock_o(core_newblock_o), .core_valid_i(core_valid_i), .core_state_i(core_state_i),
      .resp_valid(resp_valid), .resp_state(resp_state), .err_tag_mismatch(err_tag_mismatch)
   );
   always #5 clk = ~clk;
   // core model: echoes state with fixed latency, deliberately not reset
   initial for (int k = 0; k < L; k++) begin pv[k] = 1'b0; ps[k] = '0; end
   always @(posedge clk) begin
      pv[0] <= core_valid_o;
      ps[0] <= core_state_o;
      for (int k = 1; k < L; k++) begin pv[k] <= pv[k-1]; ps[k] <= ps[k-1]; end
   end
   assign core_valid_i = pv[L-1] | inj;
   assign core_state_i = ps[L-1];

   typedef struct { int due; int id; logic [255:0] st; } exp_t;
   typedef struct { logic [1:0] v; logic [1:0] last; logic [1:0] ex; } vec_t;
   exp_t sb[$];
   vec_t tbl[$];
   int errs = 0, checks = 0, cyc = 0;
   int cred[N];
   int ptr_m, lock_m;
   bit err_m, pacc;
   logic [511:0] pW;
   logic [255:0] pS;
   logic pNB;

   task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) cred[i] = 0;
      ptr_m = 0; lock_m = -1; err_m = 0; pacc = 0;
      sb.delete();
   endtask

   function automatic int model_grant(input logic [1:0] v);
      if (!rst) return -1;
      if (lock_m >= 0) return (v[lock_m] && cred[lock_m] < MAXO) ? lock_m : -1;
      for (int k = 0; k < N; k++) begin
         int i = (ptr_m + k) % N;
         if (v[i] && cred[i] < MAXO) return i;
      end
      return -1;
   endfunction

   task automatic step(input logic [1:0] v, input logic [1:0] last, input logic [1:0] nb,
                       input logic ij, input logic tchk, input logic [1:0] tex, input string tn);
      int g;
      bit erv;
      exp_t e;
      req_valid = v; req_last = last; req_newblock = nb; inj = ij;
      for (int i = 0; i < N; i++) begin
         for (int w = 0; w < 16; w++) req_W[i][w] = $urandom;
         for (int w = 0; w < 8; w++) req_state[i][w] = $urandom;
         req_state[i][0] = 32'(i);
      end
      @(negedge clk);
      g = model_grant(v);
      chk("req_ready", req_ready, (g >= 0) ? 2'(1 << g) : 2'b00);
      if (tchk) chk(tn, req_ready, tex);
      chk("core_valid_o", core_valid_o, pacc);
      if (pacc) begin
         chk("core_W_o", core_W_o, pW);
         chk("core_state_o", core_state_o, pS);
         chk("core_newblock_o", core_newblock_o, pNB);
      end
      erv = sb.size() > 0 && sb[0].due == cyc;
      chk("resp_valid", resp_valid, erv ? 2'(1 << sb[0].id) : 2'b00);
      if (erv) chk("resp_state", resp_state, sb[0].st);
      chk("err_tag_mismatch", err_tag_mismatch, err_m);
      if (erv) begin cred[sb[0].id]--; void'(sb.pop_front()); end
      if (core_valid_i != (sb.size() > 0 && sb[0].due == cyc + 1)) err_m = 1;
      pacc = g >= 0;
      if (pacc) begin
         pW = req_W[g]; pS = req_state[g]; pNB = nb[g];
         cred[g]++;
         e.due = cyc + L + 2; e.id = g; e.st = req_state[g];
         sb.push_back(e);
         if (lock_m < 0) ptr_m = (g + 1) % N;
         lock_m = last[g] ? -1 : g;
      end
      @(posedge clk);
      #1;
      cyc++;
      inj = 1'b0;
   endtask

   task automatic add(input logic [1:0] v, input logic [1:0] last, input logic [1:0] ex, input int n);
      vec_t t;
      t.v = v; t.last = last; t.ex = ex;
      repeat (n) tbl.push_back(t);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // round robin, then multi-block lock, lock+withdraw, lock+credit, credit limit
      add(2'b11, 2'b11, 2'b01, 1); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b11, 2'b11, 2'b01, 1); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b00, 2'b00, 2'b00, 12);
      add(2'b11, 2'b10, 2'b01, 2); add(2'b11, 2'b11, 2'b01, 1); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b00, 2'b00, 2'b00, 12);
      add(2'b11, 2'b10, 2'b01, 1); add(2'b10, 2'b10, 2'b00, 1);
      add(2'b11, 2'b11, 2'b01, 1); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b00, 2'b00, 2'b00, 12);
      add(2'b11, 2'b10, 2'b01, 4); add(2'b11, 2'b10, 2'b00, 7);
      add(2'b11, 2'b11, 2'b01, 1); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b00, 2'b00, 2'b00, 12);
      add(2'b01, 2'b11, 2'b01, 4); add(2'b11, 2'b11, 2'b10, 1);
      add(2'b01, 2'b11, 2'b00, 6); add(2'b01, 2'b11, 2'b01, 1);
      add(2'b00, 2'b00, 2'b00, 12);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (5) step(2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, "");
      #2 rst = 1'b0;
      #1;
      chk("rst req_ready", req_ready, 2'b00);
      chk("rst core_valid_o", core_valid_o, 1'b0);
      chk("rst core_W_o", core_W_o, '0);
      chk("rst core_state_o", core_state_o, '0);
      chk("rst core_newblock_o", core_newblock_o, 1'b0);
      chk("rst resp_valid", resp_valid, 2'b00);
      chk("rst err_tag_mismatch", err_tag_mismatch, 1'b0);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      repeat (L + 4) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "");
      do_reset();
      foreach (tbl[i]) step(tbl[i].v, tbl[i].last, 2'b11, 1'b0, 1'b1, tbl[i].ex, $sformatf("tbl[%0d]", i));
      repeat (400) step(2'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b0, 2'b00, "");
      repeat (L + 4) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "");
      step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, "");
      repeat (2) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "");
      repeat (4) step(2'b01, 2'b11, 2'b11, 1'b0, 1'b1, 2'b01, "post_err_credit");
      step(2'b01, 2'b11, 2'b11, 1'b0, 1'b1, 2'b00, "post_err_limit");
      repeat (L + 4) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
